mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared physical-memory arbiter for the LC-3b pipeline. Sits between the instruction cache (fetch side) and the data cache (MEM side) and a single line-wide physical memory port, serialising misses and write-backs. Its `arb_busy` output feeds the pipeline stall network, where a pending data-side transaction shows up as the MEM-stage stall.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: byte address width (`lc3b_word`).
- `LINE_WIDTH`, default 128: cache line width (`lc3b_line`).

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `i_read`, input, 1: I-cache line read request; held high until `i_resp`.
- `i_address`, input, `ADDR_WIDTH`: I-side line address; stable while `i_read` is high.
- `i_rdata`, output, `LINE_WIDTH`: returned line; valid when `i_resp` is high.
- `i_resp`, output, 1: one-cycle completion pulse for the I side.
- `d_read`, input, 1: D-cache line read request; held until `d_resp`.
- `d_write`, input, 1: D-cache write-back request; held until `d_resp`.
- `d_address`, input, `ADDR_WIDTH`: D-side line address.
- `d_wdata`, input, `LINE_WIDTH`: write-back line.
- `d_rdata`, output, `LINE_WIDTH`: returned line; valid when `d_resp` is high.
- `d_resp`, output, 1: one-cycle completion pulse for the D side.
- `pmem_read`, output, 1: physical memory read strobe.
- `pmem_write`, output, 1: physical memory write strobe.
- `pmem_address`, output, `ADDR_WIDTH`: physical memory address.
- `pmem_wdata`, output, `LINE_WIDTH`: physical memory write data.
- `pmem_rdata`, input, `LINE_WIDTH`: physical memory read data; valid with `pmem_resp`.
- `pmem_resp`, input, 1: physical memory completion pulse.
- `arb_busy`, output, 1: high in every state except IDLE.

## Operation
State machine with four states: IDLE, I_XFER, D_XFER, DONE.

- **IDLE**
  - Samples `i_read`, `d_read` and `d_write`.
  - If any request is high, latches the winner's address, write data and op (read/write) into the request registers and moves to I_XFER or D_XFER.
  - With no request, stays in IDLE.
- **I_XFER / D_XFER**
  - Drives `pmem_read` or `pmem_write` and `pmem_address`/`pmem_wdata` from the latched registers, never from live inputs.
  - On `pmem_resp`, captures `pmem_rdata` into the line buffer and moves to DONE.
- **DONE**
  - Pulses `i_resp` or `d_resp` for exactly one cycle, with `i_rdata`/`d_rdata` driven from the line buffer.
  - Always moves to IDLE.
- **Arbitration:** default policy is fixed priority, D over I. D-side misses belong to the older instruction.
- **Illegal `d_read` and `d_write` together:** treated as a write.
- **Requester drops its request mid-transaction:** the transaction still completes and `resp` still pulses. Requesters must not drop, per protocol.
- **Requester keeps its request high in the cycle after `resp`:** a new transaction starts. The caches must deassert in that cycle.
- **`pmem_resp` outside an XFER state:** ignored.
- **Reset (`reset_n` low at an edge):**
  - State goes to IDLE and any in-flight transaction is abandoned.
  - All outputs read 0: `pmem_*` strobes, `*_resp`, `arb_busy`, `*_rdata`, line buffer.
  - A `pmem_resp` that arrives afterwards is ignored.

## Timing
- **Cycle 0:** request seen in IDLE.
- **Cycle 1:** `pmem_*` strobe high, `arb_busy` high.
- **Cycle N:** `pmem_resp` seen; strobe drops in cycle N+1.
- **Cycle N+1:** `*_resp` high (DONE).
- **Cycle N+2:** IDLE; back-to-back requests are arbitrated here.
- Minimum latency is 3 cycles, when `pmem_resp` arrives in cycle 1. The idle cycle between transactions is mandatory.
- `*_rdata` holds the buffer value until the next capture.

## Configuration
- **`MEM_ARBITER_RR_EN` defined:** round-robin arbitration.
  - A `last_grant` register is updated on entry to an XFER state.
  - On a tie, the side not granted last wins.
  - `last_grant` resets to D, so I wins the first tie.
- **Undefined:** fixed D-over-I priority, and no `last_grant` register exists.

## Structure
- Package `lc3b_types` holds `lc3b_word`, `lc3b_line` and an enum `arb_state_t` (IDLE, I_XFER, D_XFER, DONE).
- Optional sub-module `mem_arbiter_select`: combinational winner selection from the requests and `last_grant`, with the RR macro applied inside it.

## Test plan
- **Single I read:** `i_read=1`, `i_address=16'h1230`, memory returns line `128'hA5…` two cycles after the strobe. Expect `pmem_read` in cycle 1, `pmem_address=16'h1230`, `i_resp` for one cycle carrying `i_rdata=128'hA5…`, `d_resp` never high.
- **Simultaneous I read and D write, `MEM_ARBITER_RR_EN` undefined:** the D write (`d_address=16'h4000`, `d_wdata=128'h1`) is served first with `pmem_write=1`. The I read starts on the IDLE cycle after `d_resp`.
- **Repeated simultaneous requests, `MEM_ARBITER_RR_EN` defined:** grants alternate I, D, I, D, starting with I after reset.
- **Reset mid-transaction:** assert `reset_n=0` in D_XFER, then give `pmem_resp` one cycle after release. Expect all outputs 0, state IDLE, no `d_resp`.
- **Address change mid-transfer:** change `i_address` during I_XFER. `pmem_address` keeps the latched value.
- **Read and write together:** `d_read=1` and `d_write=1` together. A single write is performed.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter: word/line types and the
// arbiter state and side encodings.
package lc3b_types;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LINE_W = 128;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_t;

endpackage

// File: rtl/mem_arbiter_select.sv
// Combinational winner selection between the I and D requesters.
// MEM_ARBITER_RR_EN selects round-robin on ties; otherwise D beats I.
module mem_arbiter_select
  import lc3b_types::*;
(
  input  logic      i_req_i,
  input  logic      d_req_i,
`ifdef MEM_ARBITER_RR_EN
  input  arb_side_t last_grant_i,
`endif
  output logic      grant_o,
  output arb_side_t side_o
);

  // Pick the side to serve; only meaningful when grant_o is high.
  always_comb begin
    grant_o = i_req_i | d_req_i;
    side_o  = SIDE_I;
`ifdef MEM_ARBITER_RR_EN
    if (i_req_i && d_req_i) begin
      side_o = (last_grant_i == SIDE_D) ? SIDE_I : SIDE_D;
    end else if (d_req_i) begin
      side_o = SIDE_D;
    end else begin
      side_o = SIDE_I;
    end
`else
    if (d_req_i) begin
      side_o = SIDE_D;
    end else begin
      side_o = SIDE_I;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache reads and D-cache reads/write-backs onto one line-wide
// physical memory port. Optional round-robin via MEM_ARBITER_RR_EN.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  arb_busy
);

  arb_state_t            state_q, state_d;
  arb_side_t             side_q, side_d, sel_side_s;
  logic                  sel_grant_s;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
`ifdef MEM_ARBITER_RR_EN
  arb_side_t             last_grant_q, last_grant_d;
`endif

  mem_arbiter_select u_select (
    .i_req_i      (i_read),
    .d_req_i      (d_read | d_write),
`ifdef MEM_ARBITER_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .grant_o      (sel_grant_s),
    .side_o       (sel_side_s)
  );

  // State and request/line registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      side_q       <= SIDE_I;
      write_q      <= 1'b0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= {LINE_WIDTH{1'b0}};
      line_q       <= {LINE_WIDTH{1'b0}};
`ifdef MEM_ARBITER_RR_EN
      last_grant_q <= SIDE_D;
`endif
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      line_q       <= line_d;
`ifdef MEM_ARBITER_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Next state; the request is latched in IDLE so pmem never sees live inputs.
  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    line_d       = line_q;
`ifdef MEM_ARBITER_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_grant_s) begin
          side_d = sel_side_s;
`ifdef MEM_ARBITER_RR_EN
          last_grant_d = sel_side_s;
`endif
          if (sel_side_s == SIDE_D) begin
            addr_d  = d_address;
            wdata_d = d_wdata;
            write_d = d_write;
            state_d = D_XFER;
          end else begin
            addr_d  = i_address;
            wdata_d = {LINE_WIDTH{1'b0}};
            write_d = 1'b0;
            state_d = I_XFER;
          end
        end else begin
          state_d = IDLE;
        end
      end
      I_XFER, D_XFER: begin
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          state_d = DONE;
        end else begin
          state_d = state_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode straight from registered state.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    arb_busy   = (state_q != IDLE);
    case (state_q)
      I_XFER, D_XFER: begin
        pmem_read  = ~write_q;
        pmem_write = write_q;
      end
      DONE: begin
        i_resp = (side_q == SIDE_I);
        d_resp = (side_q == SIDE_D);
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = line_q;
  assign d_rdata      = line_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory plus a
// transaction-level model of arbitration, latency and returned data.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_read, d_read, d_write;
  logic [15:0]  i_address, d_address;
  logic [127:0] d_wdata, i_rdata, d_rdata;
  logic         i_resp, d_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = 128'd0;
  logic         arb_busy;

  int n_checks = 0;
  int n_pass   = 0;

  // memory model state
  logic         mem_en   = 1'b1;
  logic         mem_resp = 1'b0;
  logic         inj_resp = 1'b0;
  int           mem_lat  = 0;
  int           mem_cnt  = 0;
  logic [127:0] mem [logic [15:0]];

  bit model_last_d = 1'b1;
  bit grant_log[$];

  always #5 clk = ~clk;

  assign pmem_resp = mem_en ? mem_resp : inj_resp;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_busy(arb_busy)
  );

  function automatic logic [127:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    if (a == 16'h1230) return {16{8'hA5}};
    return {8{a}};
  endfunction

  // Physical memory: answers a strobe after mem_lat further cycles.
  always @(negedge clk) begin
    if (!mem_en) begin
      mem_resp = 1'b0;
      mem_cnt  = 0;
    end else if ((pmem_read || pmem_write) && !mem_resp) begin
      if (mem_cnt >= mem_lat) begin
        mem_resp = 1'b1;
        mem_cnt  = 0;
        if (pmem_write) mem[pmem_address] = pmem_wdata;
        else pmem_rdata = mem_rd(pmem_address);
      end else begin
        mem_cnt = mem_cnt + 1;
      end
    end else begin
      mem_resp = 1'b0;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = 16'd0; d_address = 16'd0; d_wdata = 128'd0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    model_last_d = 1'b1;
    n_checks++;
    if ({arb_busy, pmem_read, pmem_write, i_resp, d_resp} !== 5'b0) begin
      $display("FAIL reset_ctrl: got %b, expected 00000", {arb_busy, pmem_read, pmem_write, i_resp, d_resp});
    end else n_pass++;
    n_checks++;
    if (i_rdata !== 128'd0 || d_rdata !== 128'd0 || pmem_address !== 16'd0 || pmem_wdata !== 128'd0) begin
      $display("FAIL reset_data: i_rdata=%h d_rdata=%h addr=%h wdata=%h, expected all 0",
               i_rdata, d_rdata, pmem_address, pmem_wdata);
    end else n_pass++;
  endtask

  task automatic test_single_i_read();
    int k = 0;
    bit got = 1'b0, seen_d = 1'b0, strobe_ok = 1'b0;
    mem_lat = 2;
    i_address = 16'h1230;
    i_read = 1'b1;
    @(posedge clk);
    while (!got && k < 30) begin
      @(negedge clk); k++;
      if (k == 1) strobe_ok = pmem_read && !pmem_write && arb_busy && (pmem_address == 16'h1230);
      if (d_resp) seen_d = 1'b1;
      if (i_resp) begin got = 1'b1; i_read = 1'b0; end
    end
    n_checks++;
    if (!strobe_ok) $display("FAIL single_strobe: pmem_read/addr not as expected in cycle 1");
    else n_pass++;
    n_checks++;
    if (!got || k != 4) $display("FAIL single_latency: i_resp at cycle %0d (got=%0d), expected 4", k, got);
    else n_pass++;
    n_checks++;
    if (i_rdata !== {16{8'hA5}}) $display("FAIL single_rdata: got %h, expected %h", i_rdata, {16{8'hA5}});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (i_resp !== 1'b0 || arb_busy !== 1'b0 || seen_d) begin
      $display("FAIL single_pulse: i_resp=%b busy=%b d_resp_seen=%0d, expected 0 0 0", i_resp, arb_busy, seen_d);
    end else n_pass++;
  endtask

  // Run the given requests to completion, checking each grant against the model.
  task automatic run_round(input bit ir, input bit dr, input bit dw,
                           input logic [15:0] ia, input logic [15:0] da,
                           input logic [127:0] wd, input bit scramble);
    bit pend_i, pend_d, exp_d, exp_wr, got, strobe_ok, resp_ok;
    logic [15:0] exp_a;
    logic [127:0] exp_rd, act_rd;
    int k;
    i_read = ir; i_address = ia;
    d_read = dr; d_write = dw; d_address = da; d_wdata = wd;
    pend_i = ir; pend_d = dr | dw;
    while (pend_i || pend_d) begin
      if (pend_i && pend_d) exp_d = RR_MODE ? !model_last_d : 1'b1;
      else exp_d = pend_d;
      model_last_d = exp_d;
      exp_wr = exp_d && dw;
      exp_a  = exp_d ? da : ia;
      mem_lat = scramble ? 2 : $urandom_range(0, 3);
      @(posedge clk);
      k = 0; got = 1'b0; strobe_ok = 1'b1;
      while (!got && k < 40) begin
        @(negedge clk); k++;
        if (k <= mem_lat + 1) begin
          if (pmem_write !== exp_wr || pmem_read !== !exp_wr || pmem_address !== exp_a ||
              (exp_wr && pmem_wdata !== wd) || arb_busy !== 1'b1) strobe_ok = 1'b0;
          if (scramble) begin
            if (exp_d) begin d_address = ~da; d_wdata = ~wd; end
            else i_address = ~ia;
          end
        end
        if (i_resp || d_resp) begin
          got = 1'b1;
          resp_ok = ({i_resp, d_resp} === {!exp_d, exp_d}) && (k == mem_lat + 2);
          exp_rd = mem_rd(exp_a);
          act_rd = exp_d ? d_rdata : i_rdata;
          grant_log.push_back(d_resp);
          n_checks++;
          if (!resp_ok) $display("FAIL round_resp: i_resp=%b d_resp=%b at cycle %0d, expected side_d=%0d at cycle %0d",
                                 i_resp, d_resp, k, exp_d, mem_lat + 2);
          else n_pass++;
          if (!exp_wr) begin
            n_checks++;
            if (act_rd !== exp_rd) $display("FAIL round_rdata: got %h, expected %h", act_rd, exp_rd);
            else n_pass++;
          end
          if (exp_d) begin d_read = 1'b0; d_write = 1'b0; pend_d = 1'b0; end
          else begin i_read = 1'b0; pend_i = 1'b0; end
        end
      end
      n_checks++;
      if (!strobe_ok) $display("FAIL round_strobe: pmem op/address/wdata wrong, expected wr=%0d addr=%h", exp_wr, exp_a);
      else n_pass++;
      if (!got) begin
        n_checks++;
        $display("FAIL round_timeout: no resp within 40 cycles, expected side_d=%0d", exp_d);
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pend_i = 1'b0; pend_d = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if ({arb_busy, pmem_read, pmem_write, i_resp, d_resp} !== 5'b0)
        $display("FAIL round_idle: got %b, expected 00000", {arb_busy, pmem_read, pmem_write, i_resp, d_resp});
      else n_pass++;
    end
  endtask

  task automatic test_d_write_vs_i_read();
    run_round(1'b1, 1'b0, 1'b1, 16'h2340, 16'h4000, 128'h1, 1'b0);
  endtask

  task automatic test_rw_together();
    int writes_before = grant_log.size();
    run_round(1'b0, 1'b1, 1'b1, 16'h0, 16'h5550, {4{32'hDEADBEEF}}, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (arb_busy !== 1'b0 || grant_log.size() != writes_before + 1 || mem_rd(16'h5550) !== {4{32'hDEADBEEF}})
      $display("FAIL rw_together: busy=%b grants=%0d line=%h, expected single write", arb_busy,
               grant_log.size() - writes_before, mem_rd(16'h5550));
    else n_pass++;
  endtask

  task automatic test_addr_change();
    run_round(1'b1, 1'b0, 1'b0, 16'h7770, 16'h0, 128'd0, 1'b1);
    run_round(1'b0, 1'b0, 1'b1, 16'h0, 16'h6660, {4{$urandom}}, 1'b1);
  endtask

  task automatic test_random();
    bit ir, dr, dw;
    for (int r = 0; r < 24; r++) begin
      ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
      if (!ir && !dr && !dw) ir = 1'b1;
      run_round(ir, dr, dw, 16'($urandom_range(0, 7) * 16), 16'($urandom_range(0, 7) * 16),
                {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    mem_en = 1'b0;
    d_write = 1'b1; d_address = 16'h4440; d_wdata = {4{32'h12345678}};
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (pmem_write !== 1'b1 || arb_busy !== 1'b1) $display("FAIL reset_mid_xfer: write=%b busy=%b, expected 1 1", pmem_write, arb_busy);
    else n_pass++;
    reset_n = 1'b0; d_write = 1'b0;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    model_last_d = 1'b1;
    n_checks++;
    if ({arb_busy, pmem_read, pmem_write, i_resp, d_resp} !== 5'b0 || i_rdata !== 128'd0 || d_rdata !== 128'd0)
      $display("FAIL reset_mid_outputs: ctrl=%b rdata=%h, expected 0", {arb_busy, pmem_read, pmem_write, i_resp, d_resp}, d_rdata);
    else n_pass++;
    @(negedge clk);
    inj_resp = 1'b1;
    @(negedge clk);
    inj_resp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (d_resp || i_resp || arb_busy || pmem_read || pmem_write || d_rdata !== 128'd0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) $display("FAIL reset_mid_ignore: late pmem_resp produced activity, expected none");
    else n_pass++;
    mem_en = 1'b1;
  endtask

  task automatic test_rr_alternate();
    grant_log.delete();
    run_round(1'b1, 1'b1, 1'b0, 16'h1100, 16'h2200, 128'd0, 1'b0);
    run_round(1'b1, 1'b1, 1'b0, 16'h3300, 16'h4400, 128'd0, 1'b0);
    n_checks++;
    if (grant_log.size() != 4 || grant_log[0] != 1'b0 || grant_log[1] != 1'b1 ||
        grant_log[2] != 1'b0 || grant_log[3] != 1'b1)
      $display("FAIL rr_order: got %p, expected I,D,I,D", grant_log);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_d_write_vs_i_read();
    test_rw_together();
    test_addr_change();
    test_random();
    test_reset_mid();
`ifdef MEM_ARBITER_RR_EN
    test_rr_alternate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
